// File: rtl/rmap_pkg.sv
// rmap_pkg: shared state encoding, packet-delimiter byte codes and the
// end-of-packet test used by the RMAP FIFO write arbiter.
`default_nettype none

package rmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [7:0] C_EOP_BYTE = 8'h00;
    localparam logic [7:0] C_EEP_BYTE = 8'h01;

    function automatic logic is_eop(input logic ctrl, input logic [7:0] low_byte);
        return ctrl && ((low_byte == C_EOP_BYTE) || (low_byte == C_EEP_BYTE));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rmap_fifo_wr_arbiter.sv
// rmap_fifo_wr_arbiter: packet-atomic round-robin arbiter of two requesters onto
// one FIFO write port. Define RMAP_ARB_TIMEOUT_EN to add the stall watchdog / EEP abort.
`default_nettype none

module rmap_fifo_wr_arbiter
    import rmap_pkg::*;
#(
    parameter int DATA_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_wr,
    input  logic                  fifo_full,
    output logic [1:0]            grant,
    output logic                  timeout_evt
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_grant;
    logic [1:0]            w_grant_nxt;
    logic                  r_last;
    logic                  w_last_nxt;
    logic                  w_sel;
    logic                  w_gvalid;
    logic [DATA_WIDTH-1:0] w_gdata;
    logic                  w_xfer;
    logic                  w_end;

    // r_last / w_sel: 0 = requester 0, 1 = requester 1
    assign w_sel    = r_grant[1];
    assign w_gvalid = w_sel ? req1_valid : req0_valid;
    assign w_gdata  = w_sel ? req1_data  : req0_data;
    assign w_xfer   = (r_state == ST_GRANT) && w_gvalid && !fifo_full;
    assign w_end    = w_xfer && is_eop(w_gdata[DATA_WIDTH-1], w_gdata[7:0]);
    assign grant    = r_grant;

`ifdef RMAP_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] C_WD_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] C_EEP_WORD =
        (DATA_WIDTH'(1) << (DATA_WIDTH - 1)) | DATA_WIDTH'(C_EEP_BYTE);

    logic [CW-1:0] r_wd_cnt;
    logic [CW-1:0] w_wd_cnt_nxt;
    logic          w_wd_expired;

    assign w_wd_expired = (r_state == ST_GRANT) && !w_gvalid && (r_wd_cnt == C_WD_LIMIT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= 2'b00;
            r_last   <= 1'b1;
`ifdef RMAP_ARB_TIMEOUT_EN
            r_wd_cnt <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_last   <= w_last_nxt;
`ifdef RMAP_ARB_TIMEOUT_EN
            r_wd_cnt <= w_wd_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_last_nxt   = r_last;
`ifdef RMAP_ARB_TIMEOUT_EN
        w_wd_cnt_nxt = r_wd_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_state_nxt = ST_GRANT;
                    if (req0_valid && req1_valid)
                        w_grant_nxt = r_last ? 2'b01 : 2'b10;
                    else
                        w_grant_nxt = req0_valid ? 2'b01 : 2'b10;
                end
            end
            ST_GRANT: begin
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                    w_last_nxt  = w_sel;
                end
`ifdef RMAP_ARB_TIMEOUT_EN
                // a full-stalled but valid owner is not idle, so the count holds
                if (w_xfer) begin
                    w_wd_cnt_nxt = '0;
                end else if (!w_gvalid) begin
                    if (w_wd_expired)
                        w_state_nxt = ST_ABORT;
                    else
                        w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                end
`endif
            end
`ifdef RMAP_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!fifo_full) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = 2'b00;
                    w_last_nxt   = w_sel;
                    w_wd_cnt_nxt = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_comb begin
        fifo_data   = '0;
        fifo_wr     = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        timeout_evt = 1'b0;
        case (r_state)
            ST_GRANT: begin
                fifo_data  = w_gdata;
                fifo_wr    = w_xfer;
                req0_ready = w_xfer && !w_sel;
                req1_ready = w_xfer && w_sel;
            end
`ifdef RMAP_ARB_TIMEOUT_EN
            ST_ABORT: begin
                fifo_data   = C_EEP_WORD;
                fifo_wr     = !fifo_full;
                timeout_evt = !fifo_full;
            end
`endif
            default: begin
                fifo_wr = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rmap_fifo_wr_arbiter.sv
// tb_rmap_fifo_wr_arbiter: scenario tasks against a packet-level round-robin
// model; the watchdog scenario follows RMAP_ARB_TIMEOUT_EN.
`default_nettype none

module tb_rmap_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] req0_data = '0;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [8:0] req1_data = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [8:0] fifo_data;
    logic       fifo_wr;
    logic       fifo_full = 1'b0;
    logic [1:0] grant;
    logic       timeout_evt;

    int errors = 0;
    int checks = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] wr_dat[$];
    int         wr_cyc[$];
    int         wr_src[$];
    int         tmo_cyc[$];
    logic [8:0] exp_dat[$];
    int         exp_src[$];
    int         full_lo = -1;
    int         full_hi = -2;
    bit         rand_full = 1'b0;

    rmap_fifo_wr_arbiter #(
        .DATA_WIDTH    (9),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .fifo_data  (fifo_data),
        .fifo_wr    (fifo_wr),
        .fifo_full  (fifo_full),
        .grant      (grant),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    function automatic bit is_end(input logic [8:0] w);
        return w[8] && (w[7:0] < 8'd2);
    endfunction

    function automatic logic [8:0] rand_body();
        logic [8:0] w;
        w = 9'($urandom);
        while (is_end(w)) w = 9'($urandom);
        return w;
    endfunction

    // Whole packets alternate, starting with requester 0 after reset; once one
    // side runs dry the other side's remaining packets follow back to back.
    task automatic build_expected(input logic [8:0] f0[$], input logic [8:0] f1[$]);
        int i0 = 0;
        int i1 = 0;
        int turn = 0;
        int s;
        bit done;
        exp_dat.delete();
        exp_src.delete();
        while (i0 < f0.size() || i1 < f1.size()) begin
            if (turn == 0) s = (i0 < f0.size()) ? 0 : 1;
            else           s = (i1 < f1.size()) ? 1 : 0;
            done = 1'b0;
            while (!done) begin
                if (s == 0) begin
                    exp_dat.push_back(f0[i0]); done = is_end(f0[i0]) || (i0 + 1 >= f0.size()); i0++;
                end else begin
                    exp_dat.push_back(f1[i1]); done = is_end(f1[i1]) || (i1 + 1 >= f1.size()); i1++;
                end
                exp_src.push_back(s);
            end
            turn = 1 - s;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        fifo_full  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives queued words with valid held while words remain; records writes.
    task automatic run(input int budget);
        bit prev_eop = 1'b0;
        bit p0, p1;
        wr_dat.delete(); wr_cyc.delete(); wr_src.delete(); tmo_cyc.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            req0_valid = (q0.size() > 0);
            req0_data  = (q0.size() > 0) ? q0[0] : 9'h000;
            req1_valid = (q1.size() > 0);
            req1_data  = (q1.size() > 0) ? q1[0] : 9'h000;
            fifo_full  = rand_full ? ($urandom_range(0, 3) == 0) : (cyc >= full_lo && cyc <= full_hi);
            @(negedge clk);
            checks++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                errors++; $display("FAIL both_ready cyc=%0d got r0=%b r1=%b want one", cyc, req0_ready, req1_ready);
            end
            checks++;
            if (fifo_wr !== 1'b0 && fifo_full) begin
                errors++; $display("FAIL wr_while_full cyc=%0d got fifo_wr=%b want 0", cyc, fifo_wr);
            end
            checks++;
            if ((req0_ready !== 1'b0 && !(fifo_wr === 1'b1 && grant === 2'b01 && fifo_data === req0_data)) ||
                (req1_ready !== 1'b0 && !(fifo_wr === 1'b1 && grant === 2'b10 && fifo_data === req1_data))) begin
                errors++; $display("FAIL ready_path cyc=%0d got grant=%b wr=%b data=%h want owner word", cyc, grant, fifo_wr, fifo_data);
            end
            if (prev_eop) begin
                checks++;
                if (fifo_wr !== 1'b0 || grant !== 2'b00) begin
                    errors++; $display("FAIL bubble cyc=%0d got wr=%b grant=%b want 0/00", cyc, fifo_wr, grant);
                end
            end
            prev_eop = (fifo_wr === 1'b1) && is_end(fifo_data);
            if (fifo_wr === 1'b1) begin
                wr_dat.push_back(fifo_data);
                wr_cyc.push_back(cyc);
                wr_src.push_back(req0_ready ? 0 : (req1_ready ? 1 : 2));
            end
            if (timeout_evt === 1'b1) tmo_cyc.push_back(cyc);
            p0 = req0_ready;
            p1 = req1_ready;
            @(posedge clk); #1;
            if (p0 && q0.size() > 0) void'(q0.pop_front());
            if (p1 && q1.size() > 0) void'(q1.pop_front());
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        fifo_full  = 1'b0;
        full_lo = -1; full_hi = -2; rand_full = 1'b0;
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (wr_dat.size() != exp_dat.size() || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_count got %0d words (left %0d/%0d) want %0d", name, wr_dat.size(), q0.size(), q1.size(), exp_dat.size());
        end
        for (int i = 0; i < wr_dat.size() && i < exp_dat.size(); i++) begin
            checks++;
            if (wr_dat[i] !== exp_dat[i] || wr_src[i] != exp_src[i]) begin
                errors++;
                $display("FAIL %s_word[%0d] got %h src%0d want %h src%0d", name, i, wr_dat[i], wr_src[i], exp_dat[i], exp_src[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 9'h0AA;
        req1_valid = 1'b1; req1_data = 9'h0BB;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || fifo_wr !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || timeout_evt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b wr=%b r0=%b r1=%b tmo=%b want all 0", grant, fifo_wr, req0_ready, req1_ready, timeout_evt);
        end
        apply_reset();
    endtask

    task automatic test_single_packet();
        apply_reset();
        q0 = '{9'h0AA, 9'h0BB, 9'h100};
        q1.delete();
        run(6);
        checks++;
        if (wr_dat.size() != 3 || wr_dat[0] !== 9'h0AA || wr_dat[1] !== 9'h0BB || wr_dat[2] !== 9'h100) begin
            errors++; $display("FAIL single_data got %0d words want 0aa 0bb 100", wr_dat.size());
        end
        checks++;
        if (wr_cyc.size() != 3 || wr_cyc[0] != 1 || wr_cyc[2] != 3) begin
            errors++; $display("FAIL single_timing got first=%0d want cycles 1..3", (wr_cyc.size() > 0) ? wr_cyc[0] : -1);
        end
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL single_idle got grant=%b want 00", grant);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] f0[$];
        logic [8:0] f1[$];
        apply_reset();
        f0 = '{9'h011, 9'h101, 9'h033, 9'h044, 9'h100};
        f1 = '{9'h0A1, 9'h0A2, 9'h100, 9'h0B1, 9'h101};
        build_expected(f0, f1);
        q0 = f0; q1 = f1;
        run(30);
        compare_stream("b2b");
        checks++;
        if (wr_cyc.size() < 4 || wr_cyc[0] != 1 || wr_cyc[2] != 4) begin
            errors++; $display("FAIL b2b_gap got second packet start cycle %0d want 4", (wr_cyc.size() > 2) ? wr_cyc[2] : -1);
        end
    endtask

    task automatic test_full_stall();
        apply_reset();
        q0 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h1F0, 9'h100};
        q1.delete();
        full_lo = 3; full_hi = 7;
        run(16);
        exp_dat = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h1F0, 9'h100};
        exp_src = '{0, 0, 0, 0, 0, 0};
        compare_stream("stall");
        checks++;
        if (wr_cyc.size() != 6 || wr_cyc[2] != 8 || wr_cyc[5] != 11) begin
            errors++; $display("FAIL stall_timing got %0d writes want resume at 8, end at 11", wr_cyc.size());
        end
    endtask

    task automatic test_random();
        logic [8:0] f0[$];
        logic [8:0] f1[$];
        int n;
        for (int rep = 0; rep < 3; rep++) begin
            apply_reset();
            f0.delete(); f1.delete();
            for (int s = 0; s < 2; s++) begin
                n = $urandom_range(2, 6);
                for (int p = 0; p < n; p++) begin
                    int len = $urandom_range(1, 5);
                    for (int k = 0; k < len - 1; k++) begin
                        if (s == 0) f0.push_back(rand_body()); else f1.push_back(rand_body());
                    end
                    if (s == 0) f0.push_back(9'h100 | 9'($urandom_range(0, 1)));
                    else        f1.push_back(9'h100 | 9'($urandom_range(0, 1)));
                end
            end
            build_expected(f0, f1);
            q0 = f0; q1 = f1;
            rand_full = 1'b1;
            run(400);
            compare_stream("random");
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        q0 = '{9'h021, 9'h100};
        q1.delete();
        run(5);
        q0 = '{9'h031, 9'h032, 9'h033, 9'h100};
        run(3);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || fifo_wr !== 1'b0 || req0_ready !== 1'b0 || timeout_evt !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got grant=%b wr=%b r0=%b want 00/0/0", grant, fifo_wr, req0_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        q0 = '{9'h041, 9'h100};
        q1 = '{9'h051, 9'h100};
        exp_dat = '{9'h041, 9'h100, 9'h051, 9'h100};
        exp_src = '{0, 0, 1, 1};
        run(10);
        compare_stream("midrst");
    endtask

    task automatic test_watchdog();
        apply_reset();
        q0.delete();
        q1 = '{9'h011};
`ifdef RMAP_ARB_TIMEOUT_EN
        run(14);
        checks++;
        if (wr_dat.size() != 2 || wr_dat[0] !== 9'h011 || wr_dat[1] !== 9'h101 || wr_cyc[1] != 10 || wr_src[1] != 2) begin
            errors++; $display("FAIL wd_eep got %0d writes want 011@1 then 101@10", wr_dat.size());
        end
        checks++;
        if (tmo_cyc.size() != 1 || tmo_cyc[0] != 10) begin
            errors++; $display("FAIL wd_pulse got %0d pulses want 1 at cycle 10", tmo_cyc.size());
        end
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL wd_idle got grant=%b want 00", grant);
        end
`else
        run(30);
        checks++;
        if (wr_dat.size() != 1 || wr_dat[0] !== 9'h011 || tmo_cyc.size() != 0) begin
            errors++; $display("FAIL hold_writes got %0d writes %0d pulses want 1 and 0", wr_dat.size(), tmo_cyc.size());
        end
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin
            errors++; $display("FAIL hold_grant got grant=%b want 10", grant);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_full_stall();
        test_random();
        test_reset_mid_packet();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rmap_fifo_wr_arbiter.md
RMAP_FIFO_WR_ARBITER -- requirements
Module: rmap_fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 9, SHALL set the FIFO word width; bit DATA_WIDTH-1 is the control flag.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the stall-watchdog limit in clock cycles.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_data  input  DATA_WIDTH  requester 0 word.
REQ-006 req0_valid  input  1  requester 0 word present.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 req1_data / req1_valid / req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009 fifo_data  output  DATA_WIDTH  word to FIFO write port.
REQ-010 fifo_wr  output  1  FIFO write enable.
REQ-011 fifo_full  input  1  FIFO full flag.
REQ-012 grant  output  2  one-hot owner of the FIFO; 2'b00 when idle.
REQ-013 timeout_evt  output  1  one-cycle pulse on watchdog abort.

Function
REQ-014 End-of-packet word SHALL be any word with bit DATA_WIDTH-1 = 1 and low byte 0x00 (EOP) or 0x01 (EEP).
REQ-015 States SHALL be IDLE, GRANT and ABORT; ABORT is reachable only with the watchdog enabled.
REQ-016 In IDLE with any valid, the block SHALL register grant on the next edge and enter GRANT; with no valid, it SHALL stay in IDLE with grant 00.
REQ-017 Arbitration SHALL be round-robin: when both requesters are valid in IDLE, the block SHALL grant the requester that is not last_grant.
REQ-018 With a single requester valid, that requester SHALL be granted regardless of last_grant.
REQ-019 In GRANT, fifo_wr, the granted ready and fifo_data SHALL be combinational: fifo_wr = granted valid & !fifo_full; fifo_data = granted data.
REQ-020 The non-granted ready SHALL be 0 at all times; in IDLE and ABORT, both readies SHALL be 0.
REQ-021 A transfer of an EOP or EEP word SHALL return the block to IDLE on the same edge, update last_grant, and clear grant.
REQ-022 Consequence: one bubble cycle SHALL occur between consecutive packets; a packet SHALL never be interleaved with another.
REQ-023 fifo_full high SHALL stall the transfer with no data loss and no change to the watchdog counter.

Reset
REQ-024 During rst the outputs SHALL take these values: state IDLE, grant 00, last_grant = requester 1 (so requester 0 wins the first tie), watchdog counter 0, timeout_evt 0.
REQ-025 During rst, fifo_wr and both readies SHALL be 0.
REQ-026 Reset mid-packet SHALL abandon the packet immediately; no EEP SHALL be emitted.

Configuration
REQ-027 With RMAP_ARB_TIMEOUT_EN defined, a counter SHALL increment on each GRANT cycle where the granted valid is 0, and SHALL clear on every transfer.
REQ-028 With RMAP_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 the block SHALL enter ABORT.
REQ-029 In ABORT, the block SHALL write one EEP word (control bit set, low byte 0x01) when !fifo_full.
REQ-030 The same cycle as that EEP write, the block SHALL pulse timeout_evt, update last_grant, and return to IDLE.
REQ-031 Without RMAP_ARB_TIMEOUT_EN, no counter or ABORT logic SHALL exist, timeout_evt SHALL be tied 0, and a stalled owner SHALL hold the grant indefinitely.

Structure
REQ-032 rmap_pkg SHALL hold the state enum, the EOP/EEP low-byte constants, and an is_eop helper function.
REQ-033 No sub-module is required; the block SHALL be a single module that drives the FIFO write interface directly.

Verification
REQ-034 After reset, req0 sends 0x0AA, 0x0BB, 0x100 with req1 idle -> grant 01 one cycle later, three fifo_wr pulses with data in order, then grant 00.
REQ-035 req0 and req1 both valid from reset -> req0 packet, one idle cycle, req1 packet, then req0 again; no interleave.
REQ-036 fifo_full held high 5 cycles mid-packet -> fifo_wr 0 for 5 cycles, req ready 0, and no word lost or duplicated.
REQ-037 With the macro and TIMEOUT_CYCLES=8, req1 sends 0x011 then drops valid -> after 8 idle cycles, fifo_data 0x101 is written, timeout_evt pulses once, and grant returns to 00.
REQ-038 rst asserted mid-packet, then released -> outputs at reset values, no EEP written, and a fresh arbitration favours req0.
